snoop_receptor: RTL
===================

# snoop_receptor

Bus-side snooping coherence controller for one cache line. Sits downstream of the processor-side emitter FSM on the shared bus: it queues coherence messages arriving from other processors, walks the line's MSI-style state (invalid/exclusive/shared) in response, and runs a write-back handshake with memory when a remote miss hits a locally exclusive line. The emitter's state output feeds the local load port, so both machines track the same line.

## Interface
- DEPTH, 4: message FIFO entries; power of two, at least 2.
- CW, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- bus_valid  in  1  a message is on the bus this cycle.
- bus_msg  in  2  message code: 00 read miss, 01 write miss, 10 invalidate, 11 empty.
- bus_ready  out  1  FIFO can accept a message; equals !full.
- local_load  in  1  load line state from the local emitter this cycle.
- local_state  in  2  state to load: 00 invalid, 01 exclusive, 10 shared.
- wb_req  out  1  write-back request to memory; held until acknowledged.
- wb_ack  in  1  memory has accepted the write-back block.
- abort_mem  out  1  one-cycle pulse: abort the requester's memory access, data supplied by write-back.
- state  out  2  current line state, same encoding as local_state.
- proto_err  out  1  one-cycle pulse: illegal message for the current state.
- count  out  CW  FIFO occupancy.
- busy  out  1  controller is in WB_WAIT.

## Operation
- Push happens when bus_valid && bus_ready && bus_msg != 11. Empty messages (11) are discarded and never queued.
- FIFO is FIFO-ordered, with wrapping pointers. There is no push when full, even if a pop happens in the same cycle.
- Controller states:
  - IDLE: handles local loads and pops messages.
  - WB_WAIT: a write-back is outstanding.
- In IDLE, local_load has priority. If local_load is high: state <= local_state and nothing is popped. A local_state of 11 is ignored.
- Otherwise, if the FIFO is non-empty, IDLE pops the head message and applies it in the same cycle.
- Line transitions on a popped message:
  - invalid, any message: stays invalid, no action.
  - shared, read miss: stays shared.
  - shared, write miss: goes to invalid.
  - shared, invalidate: goes to invalid.
  - exclusive, read miss: go to WB_WAIT with target state shared.
  - exclusive, write miss: go to WB_WAIT with target state invalid.
  - exclusive, invalidate: goes to invalid, pulses proto_err, no write-back.
- WB_WAIT behaviour:
  - wb_req = 1 and busy = 1; nothing is popped; local_load is ignored.
  - On wb_ack: state <= target state, abort_mem pulses, controller returns to IDLE.
  - The FIFO keeps accepting messages while in WB_WAIT.
- Reset values: state 00, count 0, FIFO pointers 0, wb_req 0, abort_mem 0, proto_err 0, busy 0, controller IDLE, bus_ready 1.

## Timing
- Message accepted at edge N. Earliest pop and state update is at edge N+1.
- A back-to-back stream without write-backs retires one message per cycle.
- Write-back sequence:
  - Pop at edge P; wb_req is high from P until the edge that samples wb_ack=1.
  - At that edge A: state is updated, wb_req drops, and abort_mem is high for exactly the cycle after A.
  - Minimum cost is 2 cycles per write-back message, when wb_ack is already high at P+1.
- wb_ack is sampled only in WB_WAIT; wb_ack asserted in IDLE is ignored.
- local_load arriving together with a non-empty FIFO delays the pop by one cycle.
- Reset during WB_WAIT: wb_req drops immediately (asynchronously), the queued messages are lost, and state goes to invalid.
- count updates at the edge of each push/pop. A simultaneous push and pop leaves count unchanged.

## Structure
- Package snoop_pkg holds the shared encodings used by the emitter and the receptor:
  - line-state localparams (invalid, exclusive, shared);
  - bus message codes (read miss, write miss, invalidate, empty);
  - processor action codes.
- Sub-module snoop_msg_fifo holds the DEPTH×2 storage, pointers, count, full and empty.
- snoop_receptor contains the controller FSM, the target-state register and the output pulses.

## Test plan
- Reset, then local_load with 01, then push a read miss -> wb_req high; with wb_ack held 3 cycles later -> state 10, one abort_mem pulse, busy 0.
- From shared (local_load 10), push write miss -> state 00 one cycle after acceptance; wb_req never asserts.
- From invalid, push 5 messages back-to-back with DEPTH=4 and no pops possible (hold local_load every cycle) -> bus_ready 0 after the 4th, count 4, the 5th is not accepted.
- From exclusive, push invalidate -> proto_err single pulse, state 00, no wb_req.
- From exclusive, push write miss then read miss; assert reset while in WB_WAIT -> wb_req 0 immediately, count 0, state 00. After reset release, bus_msg 11 with bus_valid -> count stays 0.

Source files
------------

// File: rtl/snoop_pkg.sv
// rtl/snoop_pkg.sv - shared coherence encodings for the snoop emitter and receptor
package snoop_pkg;

  // line states
  localparam logic [1:0] ST_INVALID   = 2'b00;
  localparam logic [1:0] ST_EXCLUSIVE = 2'b01;
  localparam logic [1:0] ST_SHARED    = 2'b10;

  // bus message codes
  localparam logic [1:0] MSG_READ_MISS  = 2'b00;
  localparam logic [1:0] MSG_WRITE_MISS = 2'b01;
  localparam logic [1:0] MSG_INVALIDATE = 2'b10;
  localparam logic [1:0] MSG_EMPTY      = 2'b11;

  // processor action codes (emitter side)
  localparam logic [1:0] PR_READ_HIT   = 2'b00;
  localparam logic [1:0] PR_READ_MISS  = 2'b01;
  localparam logic [1:0] PR_WRITE_HIT  = 2'b10;
  localparam logic [1:0] PR_WRITE_MISS = 2'b11;

  typedef enum logic {
    CTRL_IDLE    = 1'b0,
    CTRL_WB_WAIT = 1'b1
  } ctrl_e;

  // 11 is not a line state; loads carrying it are dropped
  function automatic logic is_line_state(input logic [1:0] s);
    return s != 2'b11;
  endfunction

endpackage

// File: rtl/snoop_msg_fifo.sv
// rtl/snoop_msg_fifo.sv - DEPTH x 2-bit message queue with wrapping pointers
module snoop_msg_fifo
  import snoop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [1:0]    din,
  output logic [1:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  // a full queue refuses writes even when the head leaves in the same cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // storage write; contents need no reset since count guards every read
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/snoop_receptor.sv
// rtl/snoop_receptor.sv - bus-side snooping controller for one cache line
module snoop_receptor
  import snoop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          bus_valid,
  input  logic [1:0]    bus_msg,
  output logic          bus_ready,
  input  logic          local_load,
  input  logic [1:0]    local_state,
  output logic          wb_req,
  input  logic          wb_ack,
  output logic          abort_mem,
  output logic [1:0]    state,
  output logic          proto_err,
  output logic [CW-1:0] count,
  output logic          busy
);

  ctrl_e      ctrl_q, ctrl_d;
  logic [1:0] state_q, state_d;
  logic [1:0] target_q, target_d;
  logic       abort_q, abort_d;
  logic       perr_q, perr_d;
  logic       pop;
  logic       push;
  logic [1:0] head;
  logic       full;
  logic       empty;

  assign push = bus_valid && (bus_msg != MSG_EMPTY);

  snoop_msg_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus_msg),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus_ready = !full;
  // combinational from the controller state so reset drops it at once
  assign wb_req    = (ctrl_q == CTRL_WB_WAIT);
  assign busy      = (ctrl_q == CTRL_WB_WAIT);
  assign state     = state_q;
  assign abort_mem = abort_q;
  assign proto_err = perr_q;

  // controller registers and one-cycle output pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q   <= CTRL_IDLE;
      state_q  <= ST_INVALID;
      target_q <= ST_INVALID;
      abort_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      state_q  <= state_d;
      target_q <= target_d;
      abort_q  <= abort_d;
      perr_q   <= perr_d;
    end
  end

  // next-state: local loads win, otherwise retire the head message
  always_comb begin
    ctrl_d   = ctrl_q;
    state_d  = state_q;
    target_d = target_q;
    abort_d  = 1'b0;
    perr_d   = 1'b0;
    pop      = 1'b0;
    case (ctrl_q)
      CTRL_IDLE: begin
        if (local_load) begin
          if (is_line_state(local_state)) state_d = local_state;
        end else if (!empty) begin
          pop = 1'b1;
          case (state_q)
            ST_SHARED: begin
              if (head != MSG_READ_MISS) state_d = ST_INVALID;
            end
            ST_EXCLUSIVE: begin
              case (head)
                MSG_READ_MISS: begin
                  ctrl_d   = CTRL_WB_WAIT;
                  target_d = ST_SHARED;
                end
                MSG_WRITE_MISS: begin
                  ctrl_d   = CTRL_WB_WAIT;
                  target_d = ST_INVALID;
                end
                default: begin
                  // a remote invalidate cannot target a line we own exclusively
                  state_d = ST_INVALID;
                  perr_d  = 1'b1;
                end
              endcase
            end
            default: ;
          endcase
        end
      end
      CTRL_WB_WAIT: begin
        if (wb_ack) begin
          state_d = target_q;
          abort_d = 1'b1;
          ctrl_d  = CTRL_IDLE;
        end
      end
      default: ctrl_d = CTRL_IDLE;
    endcase
  end

endmodule
